// File: rtl/mixed_opcode_tag_alloc_pkg.sv
// mixed_opcode_tag_alloc_pkg: opcode enum, pool geometry and tag request/return types
package mixed_opcode_tag_alloc_pkg;
  typedef enum logic [2:0] {OP_READ, OP_WRITE, OP_WAIT, OP_EVICT, OP_TRIM} opcodeEnumT;
  localparam int OPCODE_NUM_TYPES = 5;
  localparam int OPCODE_TAGS_PER_TYPE = 64;
  localparam int OPCODE_TAG_W = $clog2(OPCODE_NUM_TYPES * OPCODE_TAGS_PER_TYPE);
  typedef logic [OPCODE_TAG_W-1:0] opcodeTagT;
  localparam opcodeTagT OP_READ_BASE = opcodeTagT'(0 * OPCODE_TAGS_PER_TYPE);
  localparam opcodeTagT OP_WRITE_BASE = opcodeTagT'(1 * OPCODE_TAGS_PER_TYPE);
  localparam opcodeTagT OP_WAIT_BASE = opcodeTagT'(2 * OPCODE_TAGS_PER_TYPE);
  localparam opcodeTagT OP_EVICT_BASE = opcodeTagT'(3 * OPCODE_TAGS_PER_TYPE);
  localparam opcodeTagT OP_TRIM_BASE = opcodeTagT'(4 * OPCODE_TAGS_PER_TYPE);
  typedef struct packed {opcodeEnumT op_type;} tagReqSt;
  typedef struct packed {opcodeTagT tag;} tagRetSt;
endpackage

// File: rtl/mixed_opcode_tag_alloc_if.sv
// mixed_opcode_tag_alloc_if: request/return/status bundle between front-end and tag allocator
interface mixed_opcode_tag_alloc_if #(
  parameter int NUM_TYPES = 5,
  parameter int TAGS_PER_TYPE = 64,
  parameter int TYPE_W = 3,
  parameter int TAG_W = 9,
  parameter int CNT_W = $clog2(TAGS_PER_TYPE) + 1
);
  logic alloc_valid;
  logic [TYPE_W-1:0] alloc_type;
  logic alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic free_valid;
  logic [TAG_W-1:0] free_tag;
  logic [NUM_TYPES*CNT_W-1:0] outstanding;
  logic [NUM_TYPES-1:0] pool_empty;
  logic err_double_free;
  logic err_bad_type;
  logic err_clr;
  modport master (
    output alloc_valid, alloc_type, free_valid, free_tag, err_clr,
    input alloc_ready, alloc_tag, outstanding, pool_empty, err_double_free, err_bad_type
  );
  modport slave (
    input alloc_valid, alloc_type, free_valid, free_tag, err_clr,
    output alloc_ready, alloc_tag, outstanding, pool_empty, err_double_free, err_bad_type
  );
endinterface

// File: rtl/mixed_find_first_zero.sv
// mixed_find_first_zero: index of the lowest clear bit plus an all-set flag
module mixed_find_first_zero #(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic all_ones
);
  // scan high to low so the lowest zero is the last one written
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (!vec[i]) idx = IDX_W'(i);
    all_ones = &vec;
  end
endmodule

// File: rtl/mixed_opcode_tag_alloc.sv
// mixed_opcode_tag_alloc: per-type tag pools with lowest-free allocation, return checking and counts
module mixed_opcode_tag_alloc
  import mixed_opcode_tag_alloc_pkg::*;
#(
  parameter int NUM_TYPES = OPCODE_NUM_TYPES,
  parameter int TAGS_PER_TYPE = OPCODE_TAGS_PER_TYPE,
  parameter int TYPE_W = 3,
  parameter int IDX_W = $clog2(TAGS_PER_TYPE),
  parameter int TAG_W = OPCODE_TAG_W,
  parameter int CNT_W = IDX_W + 1
) (
  input logic clk,
  input logic rst,
  mixed_opcode_tag_alloc_if.slave bus
);
  logic [TAGS_PER_TYPE-1:0] used [NUM_TYPES];
  logic [CNT_W-1:0] cnt [NUM_TYPES];
  logic [IDX_W-1:0] ffz_idx [NUM_TYPES];
  logic [NUM_TYPES-1:0] ffz_full;
  logic [NUM_TYPES*CNT_W-1:0] out_v;
  logic [NUM_TYPES-1:0] empty_v;
  logic [TYPE_W-1:0] a_t, f_t;
  logic [IDX_W-1:0] f_idx;
  logic a_legal, f_legal, f_hit, ready, grant, f_ok, dbl, bad;
  logic err_dbl, err_bad;

  for (genvar g = 0; g < NUM_TYPES; g++) begin : g_pool
    mixed_find_first_zero #(.WIDTH(TAGS_PER_TYPE), .IDX_W(IDX_W)) u_ffz (
      .vec(used[g]),
      .idx(ffz_idx[g]),
      .all_ones(ffz_full[g])
    );
  end

  // decode request and return against the pre-edge bitmap; illegal types steer to pool 0 but never act
  always_comb begin
    a_legal = {1'b0, bus.alloc_type} < (TYPE_W + 1)'(NUM_TYPES);
    a_t = a_legal ? bus.alloc_type : '0;
    f_legal = {1'b0, bus.free_tag} < (TAG_W + 1)'(NUM_TYPES * TAGS_PER_TYPE);
    f_t = f_legal ? TYPE_W'(bus.free_tag >> IDX_W) : '0;
    f_idx = bus.free_tag[IDX_W-1:0];
    f_hit = used[f_t][f_idx];
    ready = a_legal && !ffz_full[a_t];
    grant = bus.alloc_valid && ready;
    f_ok = bus.free_valid && f_legal && f_hit;
    dbl = bus.free_valid && f_legal && !f_hit;
    bad = (bus.alloc_valid && !a_legal) || (bus.free_valid && !f_legal);
  end

  // flatten per-type counts and full flags onto the status bus
  always_comb begin
    out_v = '0;
    empty_v = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      out_v[t*CNT_W +: CNT_W] = cnt[t];
      empty_v[t] = cnt[t] == CNT_W'(TAGS_PER_TYPE);
    end
  end

  assign bus.alloc_ready = ready;
  assign bus.alloc_tag = ready ? TAG_W'(a_t) * TAG_W'(TAGS_PER_TYPE) + TAG_W'(ffz_idx[a_t]) : '0;
  assign bus.outstanding = out_v;
  assign bus.pool_empty = empty_v;
  assign bus.err_double_free = err_dbl;
  assign bus.err_bad_type = err_bad;

  // a valid free needs a set bit and a grant needs a clear one, so they never touch the same bit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TYPES; t++) begin
        used[t] <= '0;
        cnt[t] <= '0;
      end
      err_dbl <= 1'b0;
      err_bad <= 1'b0;
    end else begin
      if (f_ok) used[f_t][f_idx] <= 1'b0;
      if (grant) used[a_t][ffz_idx[a_t]] <= 1'b1;
      for (int t = 0; t < NUM_TYPES; t++)
        cnt[t] <= cnt[t] + CNT_W'(grant && a_t == TYPE_W'(t)) - CNT_W'(f_ok && f_t == TYPE_W'(t));
      err_dbl <= dbl || (err_dbl && !bus.err_clr);
      err_bad <= bad || (err_bad && !bus.err_clr);
    end
  end
endmodule
